// File: rtl/fm_decim_squelch.sv
// fm_decim_squelch: accumulate-and-dump decimator with carrier squelch, optional DC blocker (FM_DCBLOCK_EN), output FIFO
module fm_decim_squelch #(
    parameter int IN_WIDTH   = 12,
    parameter int OUT_WIDTH  = 16,
    parameter int LOG2_DECIM = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int DC_SHIFT   = 6
) (
    input  logic                        clk_in,
    input  logic                        RST_N,
    input  logic signed [IN_WIDTH-1:0]  fm_in,
    input  logic        [IN_WIDTH-1:0]  mag_in,
    input  logic                        in_valid,
    input  logic        [IN_WIDTH-1:0]  sq_thresh,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        squelch,
    output logic                        overflow
);
    localparam int ACC_W = IN_WIDTH + LOG2_DECIM;
    localparam int PW = $clog2(FIFO_DEPTH);
    logic signed [ACC_W-1:0] acc, sum;
    logic [LOG2_DECIM-1:0] cnt;
    logic blk_low, low, dump;
    logic signed [OUT_WIDTH-1:0] scaled, samp, wr_data;
    logic samp_vld, wr_vld;
    assign sum = acc + ACC_W'(fm_in);
    assign low = blk_low || (mag_in < sq_thresh);
    assign dump = in_valid && (&cnt);
    generate
        if (ACC_W >= OUT_WIDTH) begin : g_shr
            assign scaled = OUT_WIDTH'(sum >>> (ACC_W - OUT_WIDTH));
        end else begin : g_sext
            assign scaled = OUT_WIDTH'(sum);
        end
    endgenerate
    // Accumulate valid samples, dump one gated and scaled sample per block
    always_ff @(posedge clk_in or negedge RST_N) begin
        if (!RST_N) begin
            acc <= '0;
            cnt <= '0;
            blk_low <= 1'b0;
            squelch <= 1'b0;
            samp <= '0;
            samp_vld <= 1'b0;
        end else begin
            samp_vld <= dump;
            if (dump) begin
                acc <= '0;
                cnt <= '0;
                blk_low <= 1'b0;
                squelch <= low;
                samp <= low ? '0 : scaled;
            end else if (in_valid) begin
                acc <= sum;
                cnt <= cnt + 1'b1;
                blk_low <= low;
            end
        end
    end
`ifdef FM_DCBLOCK_EN
    localparam int DW = OUT_WIDTH + 2;
    logic signed [OUT_WIDTH-1:0] x_prev, y_prev, y_sat;
    logic signed [DW-1:0] y_full;
    logic [DW-OUT_WIDTH:0] top;
    // y_prev is kept saturated, so the sum below always fits in DW bits
    assign y_full = DW'(samp) - DW'(x_prev) + DW'(y_prev) - DW'(y_prev >>> DC_SHIFT);
    assign top = y_full[DW-1:OUT_WIDTH-1];
    assign y_sat = (&top || ~|top) ? y_full[OUT_WIDTH-1:0] : {y_full[DW-1], {(OUT_WIDTH-1){~y_full[DW-1]}}};
    // DC blocker state advances once per dumped sample
    always_ff @(posedge clk_in or negedge RST_N) begin
        if (!RST_N) begin
            x_prev <= '0;
            y_prev <= '0;
            wr_data <= '0;
            wr_vld <= 1'b0;
        end else begin
            wr_vld <= samp_vld;
            if (samp_vld) begin
                x_prev <= samp;
                y_prev <= y_sat;
                wr_data <= y_sat;
            end
        end
    end
`else
    assign wr_data = samp;
    assign wr_vld = samp_vld;
`endif
    logic signed [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;
    logic full, pop, push;
    assign full = count == (PW+1)'(FIFO_DEPTH);
    assign out_valid = count != '0;
    assign out_data = mem[rd_ptr];
    assign pop = out_valid && out_ready;
    assign push = wr_vld && (!full || pop);
    // Output FIFO; a write into a full FIFO without a pop is dropped and flagged
    always_ff @(posedge clk_in or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            overflow <= wr_vld && full && !pop;
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_fm_decim_squelch.sv
// tb_fm_decim_squelch: scoreboard bench for fm_decim_squelch (default build, no DC blocker)
module tb_fm_decim_squelch;
    logic clk_in = 1'b0;
    logic RST_N;
    logic signed [11:0] fm_in;
    logic [11:0] mag_in, sq_thresh;
    logic in_valid, out_ready, squelch, overflow, out_valid;
    logic signed [15:0] out_data;
    int q[$];
    int n_chk = 0, n_pass = 0, ov_cnt = 0, ov0;

    fm_decim_squelch dut (
        .clk_in(clk_in), .RST_N(RST_N), .fm_in(fm_in), .mag_in(mag_in), .in_valid(in_valid),
        .sq_thresh(sq_thresh), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .squelch(squelch), .overflow(overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Monitor: every accepted output is compared against the scoreboard head
    always @(negedge clk_in) begin
        if (RST_N && overflow) ov_cnt++;
        if (RST_N && out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_output", int'(out_data), -99999);
            else chk("out_data", int'(out_data), q.pop_front());
        end
    end

    task automatic send(input int f, input int m);
        fm_in = f[11:0];
        mag_in = m[11:0];
        in_valid = 1'b1;
        @(posedge clk_in); #1;
        in_valid = 1'b0;
    endtask

    task automatic block(input int f, input int m, input int low_idx, input int low_m, input int gap);
        for (int i = 0; i < 8; i++) begin
            send(f, i == low_idx ? low_m : m);
            repeat (gap) begin @(posedge clk_in); #1; end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin @(posedge clk_in); #1; n++; end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0; fm_in = '0; mag_in = '0; in_valid = 1'b0; out_ready = 1'b1; sq_thresh = 12'd200;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_squelch", squelch, 0);
        chk("rst_overflow", overflow, 0);
        RST_N = 1'b1;
        @(posedge clk_in); #1;
        // 1: basic block and latency
        q.push_back(800);
        block(100, 1000, -1, 0, 0);
        chk("lat_dump_edge", out_valid, 0);
        @(posedge clk_in); #1;
        chk("lat_write_edge", out_valid, 1);
        drain();
        chk("t1_squelch", squelch, 0);
        // 2: one low-magnitude sample squelches the block, threshold boundaries
        q.push_back(0);
        block(100, 1000, 4, 199, 0);
        drain();
        chk("t2_squelch_on", squelch, 1);
        q.push_back(-296);
        block(-37, 200, -1, 0, 0);
        drain();
        chk("t2_mag_eq_thr", squelch, 0);
        sq_thresh = 12'd0;
        q.push_back(-16384);
        block(-2048, 0, -1, 0, 0);
        q.push_back(16376);
        block(2047, 5, -1, 0, 0);
        drain();
        chk("t2_thr_zero", squelch, 0);
        sq_thresh = 12'd200;
        // 3: five blocks into a stalled consumer
        out_ready = 1'b0;
        ov0 = ov_cnt;
        for (int b = 1; b <= 5; b++) begin
            if (b < 5) q.push_back(80 * b);
            block(10 * b, 1000, -1, 0, 0);
        end
        repeat (4) begin @(posedge clk_in); #1; end
        chk("t3_overflow_once", ov_cnt - ov0, 1);
        chk("t3_head_held", int'(out_data), 80);
        out_ready = 1'b1;
        drain();
        // 4: full FIFO with pop in the write cycle
        out_ready = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            q.push_back(8 * b);
            block(b, 1000, -1, 0, 0);
        end
        q.push_back(40);
        ov0 = ov_cnt;
        block(5, 1000, -1, 0, 0);
        out_ready = 1'b1;
        @(posedge clk_in); #1;
        out_ready = 1'b0;
        repeat (3) begin @(posedge clk_in); #1; end
        chk("t4_no_overflow", ov_cnt - ov0, 0);
        chk("t4_new_head", int'(out_data), 16);
        out_ready = 1'b1;
        drain();
        // 5: gapped input and reset mid-block
        q.push_back(0);
        block(50, 100, -1, 0, 2);
        drain();
        chk("t5_squelch_set", squelch, 1);
        for (int i = 0; i < 4; i++) begin
            send(500, 1000);
            repeat (2) begin @(posedge clk_in); #1; end
        end
        RST_N = 1'b0;
        @(posedge clk_in); #1;
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_squelch", squelch, 0);
        chk("t5_rst_overflow", overflow, 0);
        chk("t5_rst_data", int'(out_data), 0);
        RST_N = 1'b1;
        @(posedge clk_in); #1;
        q.push_back(24);
        block(3, 1000, -1, 0, 2);
        drain();
        chk("t5_squelch_after", squelch, 0);
        repeat (3) begin @(posedge clk_in); #1; end
        chk("final_idle", out_valid, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
